voice_mix_scheduler: RTL and testbench
======================================

Name: voice_mix_scheduler

Overview:
- Per-sample-frame scheduler that sequences the voice generators onto the single shared DAC sample path.
- On each frame tick it polls every enabled voice in fixed index order over a req/ack handshake.
- It accumulates the returned samples at full width, applies an attenuation shift, saturates to 16 bits, and publishes the held result.
- The held result drives the I2S serializer's continuous audio input.

Parameters:
- NUM_VOICES, 4, number of voice requesters (2..8).
- SAMPLE_W, 16, signed sample width for both voices and output.
- MIX_SHIFT, 2, arithmetic right shift applied to the accumulated sum before saturation.
- TIMEOUT, 16, maximum cycles spent waiting for a voice ack.

Ports:
- clk_12mhz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  single-cycle pulse, already synchronized to clk_12mhz, once per sample frame.
- voice_en  in  NUM_VOICES  per-voice enable.
- voice_req  out  1  one-cycle request strobe to the voice selected by voice_sel.
- voice_sel  out  clog2(NUM_VOICES)  index of the voice being polled.
- voice_ack  in  1  selected voice's sample is valid.
- voice_sample  in  SAMPLE_W  signed sample, qualified by voice_ack.
- mix_out  out  SAMPLE_W  signed held mix; feeds serializer audio_in.
- mix_valid  out  1  one-cycle pulse when mix_out updates.
- busy  out  1  high while in any state other than IDLE.
- overrun_err  out  1  sticky; a frame_tick arrived while busy.
- timeout_err  out  1  sticky; a voice failed to ack within TIMEOUT cycles.
- err_clr  in  1  clears both sticky error flags.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; mix_out=0; mix_valid=0; voice_req=0; voice_sel=0; busy=0; both error flags=0; accumulator=0; index=0. Reset mid-frame abandons the partial sum and issues no mix_valid.
- FSM states: IDLE, ISSUE, WAIT. All outputs are registered.
- IDLE: when frame_tick=1, clear the accumulator, set idx=0, go to ISSUE.
- ISSUE, voice_en[idx]=1: assert voice_req for this cycle only, with voice_sel=idx. Clear the wait timer and go to WAIT.
- ISSUE, voice_en[idx]=0: skip the voice in 1 cycle with no request and no contribution, then ADVANCE.
- WAIT, voice_ack=1: acc += sign-extend(voice_sample), then ADVANCE.
- WAIT, no ack: increment the timer. When timer reaches TIMEOUT-1 with no ack, set timeout_err, contribute 0, and ADVANCE.
- Ack sampling: voice_ack is sampled only in WAIT. An ack in IDLE or ISSUE, including one in the same cycle as voice_req, is ignored.
- ADVANCE: if idx==NUM_VOICES-1, publish and go to IDLE. Otherwise idx++ and go to ISSUE.
- Publish: mix_out <= sat(acc >>> MIX_SHIFT), with mix_valid=1 in the next cycle only. mix_out holds its value until the next publish.
- Accumulator width: SAMPLE_W+clog2(NUM_VOICES), signed, so it never wraps.
- Saturation: clamp to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
- Latency, all voices enabled and each ack arriving the cycle after its req: mix_valid is high exactly 2*NUM_VOICES+1 cycles after the frame_tick cycle.
- All voices disabled: publish mix_out=0 after NUM_VOICES ISSUE cycles.
- frame_tick while busy (ISSUE or WAIT): the tick is dropped, overrun_err is set, and the current frame continues unchanged.
- err_clr: clears both flags on the next edge. If err_clr and a new error event occur in the same cycle, the set wins.
- voice_en is sampled per voice in ISSUE. Changes mid-frame affect only voices not yet visited.

Decomposition:
- audio_pkg holds:
  - the SAMPLE_W default;
  - the sched_state_t enum {IDLE, ISSUE, WAIT};
  - the saturation limit constants;
  - a signed saturate function.
- One sub-module: mix_shift_sat, a combinational block (acc in, MIX_SHIFT, saturate, SAMPLE_W out). It is reused later by the gain/volume stage.

Test Plan:
- NUM_VOICES=4, MIX_SHIFT=2, samples 1000, 2000, -500, 300, immediate acks -> mix_out=700; mix_valid exactly 9 cycles after the tick.
- MIX_SHIFT=0, all voices 30000 -> mix_out=32767. All voices -30000 -> mix_out=-32768.
- voice_en=4'b1010, samples 1000/2000/3000/4000, MIX_SHIFT=0 -> voice_req seen only for sel 1 and 3; mix_out=6000.
- Voice 2 never acks, TIMEOUT=16 -> timeout_err=1. Voice 2 contributes 0 (other three sum to 2800, MIX_SHIFT=0 -> 2800). A following err_clr -> flag=0.
- Second frame_tick while in WAIT -> overrun_err=1, exactly one mix_valid for that frame. Ack asserted in IDLE -> no effect.
- Reset asserted during WAIT of voice 1 -> outputs immediately at reset values, no mix_valid. After release, the next tick produces a clean frame.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path types and helpers: scheduler states, sample width default,
// and a generic signed saturation used by the mix and gain stages.
package audio_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam logic signed [SAMPLE_W_DEF-1:0] SAT_MAX_DEF = 16'sh7FFF;
  localparam logic signed [SAMPLE_W_DEF-1:0] SAT_MIN_DEF = 16'sh8000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} sched_state_t;

  // Clamp a signed value to the range of a w-bit signed number (w <= 31).
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/voice_mix_scheduler_if.sv
// Voice polling handshake plus mix output and error status of the scheduler.
interface voice_mix_scheduler_if #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 16
);
  localparam int SEL_W = $clog2(NUM_VOICES);

  logic                       frame_tick;
  logic [NUM_VOICES-1:0]      voice_en;
  logic                       voice_req;
  logic [SEL_W-1:0]           voice_sel;
  logic                       voice_ack;
  logic signed [SAMPLE_W-1:0] voice_sample;
  logic signed [SAMPLE_W-1:0] mix_out;
  logic                       mix_valid;
  logic                       busy;
  logic                       overrun_err;
  logic                       timeout_err;
  logic                       err_clr;

  modport master (
    input  frame_tick, voice_en, voice_ack, voice_sample, err_clr,
    output voice_req, voice_sel, mix_out, mix_valid, busy, overrun_err, timeout_err
  );

  modport slave (
    output frame_tick, voice_en, voice_ack, voice_sample, err_clr,
    input  voice_req, voice_sel, mix_out, mix_valid, busy, overrun_err, timeout_err
  );
endinterface

// File: rtl/voice_mix_scheduler_mix_shift_sat.sv
// Combinational attenuate-and-clamp: arithmetic shift of a wide sum, then
// saturation to SAMPLE_W signed bits.
module mix_shift_sat
  import audio_pkg::*;
#(
  parameter int ACC_W     = 18,
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int MIX_SHIFT = 2
)(
  input  logic signed [ACC_W-1:0]    i_acc,
  output logic signed [SAMPLE_W-1:0] o_mix
);
  logic signed [ACC_W-1:0] w_shifted;

  assign w_shifted = i_acc >>> MIX_SHIFT;
  assign o_mix     = SAMPLE_W'(saturate(32'(w_shifted), SAMPLE_W));
endmodule

// File: rtl/voice_mix_scheduler.sv
// Per-frame voice scheduler: polls enabled voices in index order, sums their
// samples, and publishes a shifted/saturated mix held for the serializer.
module voice_mix_scheduler
  import audio_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int MIX_SHIFT  = 2,
  parameter int TIMEOUT    = 16
)(
  input logic                   clk_12mhz,
  input logic                   reset,
  voice_mix_scheduler_if.master bus
);
  localparam int SEL_W = $clog2(NUM_VOICES);
  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_VOICES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  sched_state_t               r_state, w_state_nxt;
  logic [SEL_W-1:0]           r_idx, w_idx_nxt;
  logic signed [ACC_W-1:0]    r_acc, w_acc_nxt;
  logic [TMR_W-1:0]           r_timer, w_timer_nxt;
  logic                       r_req, w_req_nxt;
  logic                       r_busy;
  logic                       r_mix_valid;
  logic signed [SAMPLE_W-1:0] r_mix;
  logic                       r_ovr, r_tmo;
  logic                       w_advance, w_publish, w_tmo_evt, w_ovr_evt;
  logic signed [ACC_W-1:0]    w_samp_ext;
  logic signed [SAMPLE_W-1:0] w_mix;

  assign w_samp_ext = ACC_W'(bus.voice_sample);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_acc_nxt   = r_acc;
    w_timer_nxt = r_timer;
    w_advance   = 1'b0;
    w_publish   = 1'b0;
    w_tmo_evt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.frame_tick) begin
          w_acc_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // r_req already carries this voice's enable, sampled on entry.
        if (r_req) begin
          w_timer_nxt = '0;
          w_state_nxt = WAIT;
        end else begin
          w_advance = 1'b1;
        end
      end
      WAIT: begin
        if (bus.voice_ack) begin
          w_acc_nxt = r_acc + w_samp_ext;
          w_advance = 1'b1;
        end else if (r_timer == TMR_LAST) begin
          w_tmo_evt = 1'b1;
          w_advance = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_advance) begin
      if (r_idx == LAST_IDX) begin
        w_publish   = 1'b1;
        w_state_nxt = IDLE;
      end else begin
        w_idx_nxt   = r_idx + 1'b1;
        w_state_nxt = ISSUE;
      end
    end
    w_req_nxt = (w_state_nxt == ISSUE) && bus.voice_en[w_idx_nxt];
    w_ovr_evt = bus.frame_tick && (r_state != IDLE);
  end

  mix_shift_sat #(
    .ACC_W    (ACC_W),
    .SAMPLE_W (SAMPLE_W),
    .MIX_SHIFT(MIX_SHIFT)
  ) u_mix_shift_sat (
    .i_acc(w_acc_nxt),
    .o_mix(w_mix)
  );

  always_ff @(posedge clk_12mhz or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_acc       <= '0;
      r_timer     <= '0;
      r_req       <= 1'b0;
      r_busy      <= 1'b0;
      r_mix_valid <= 1'b0;
      r_mix       <= '0;
      r_ovr       <= 1'b0;
      r_tmo       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_acc       <= w_acc_nxt;
      r_timer     <= w_timer_nxt;
      r_req       <= w_req_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_mix_valid <= w_publish;
      if (w_publish) r_mix <= w_mix;
      // A new error event wins over a simultaneous clear.
      r_ovr       <= w_ovr_evt | (r_ovr & ~bus.err_clr);
      r_tmo       <= w_tmo_evt | (r_tmo & ~bus.err_clr);
    end
  end

  assign bus.voice_req   = r_req;
  assign bus.voice_sel   = r_idx;
  assign bus.mix_out     = r_mix;
  assign bus.mix_valid   = r_mix_valid;
  assign bus.busy        = r_busy;
  assign bus.overrun_err = r_ovr;
  assign bus.timeout_err = r_tmo;
endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Scoreboard bench: two schedulers (MIX_SHIFT 2 and 0) share one stimulus and
// one voice responder; each has its own expected-mix queue and monitor.
module tb_voice_mix_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              tick = 1'b0, clr = 1'b0, ack_r = 1'b0, stray_ack = 1'b0;
  logic [3:0]        en = 4'hF;
  logic signed [15:0] sample_r = '0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  voice_mix_scheduler_if #(.NUM_VOICES(4), .SAMPLE_W(16)) ifa ();
  voice_mix_scheduler_if #(.NUM_VOICES(4), .SAMPLE_W(16)) ifb ();

  assign ifa.frame_tick = tick;     assign ifb.frame_tick = tick;
  assign ifa.voice_en = en;         assign ifb.voice_en = en;
  assign ifa.voice_ack = ack_r | stray_ack;
  assign ifb.voice_ack = ack_r | stray_ack;
  assign ifa.voice_sample = sample_r; assign ifb.voice_sample = sample_r;
  assign ifa.err_clr = clr;         assign ifb.err_clr = clr;

  voice_mix_scheduler #(.NUM_VOICES(4), .SAMPLE_W(16), .MIX_SHIFT(2), .TIMEOUT(16))
    dut_a (.clk_12mhz(clk), .reset(rst), .bus(ifa));
  voice_mix_scheduler #(.NUM_VOICES(4), .SAMPLE_W(16), .MIX_SHIFT(0), .TIMEOUT(16))
    dut_b (.clk_12mhz(clk), .reset(rst), .bus(ifb));

  int n_tests = 0, n_fail = 0;
  int exp_a[$], exp_b[$];
  int vcnt_a = 0, vcnt_b = 0, req_mask = 0;
  logic signed [15:0] samp[4];
  int dly[4];
  bit mute[4];
  int pend_sel = -1, pend_cnt = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Voice model: ack the polled voice dly[] cycles after the cycle following its req.
  initial forever begin
    @(posedge clk); #1;
    ack_r = 1'b0;
    if (pend_sel >= 0) begin
      if (pend_cnt == 0) begin
        ack_r = 1'b1; sample_r = samp[pend_sel]; pend_sel = -1;
      end else pend_cnt--;
    end
    if (ifa.voice_req && !mute[ifa.voice_sel]) begin
      pend_sel = int'(ifa.voice_sel); pend_cnt = dly[ifa.voice_sel];
    end
  end

  initial forever begin
    @(negedge clk);
    if (ifa.voice_req) req_mask |= (1 << ifa.voice_sel);
    if (ifa.mix_valid) begin
      vcnt_a++;
      if (exp_a.size() == 0) chk("mix_a_unexpected", 1, 0);
      else chk("mix_a", ifa.mix_out, exp_a.pop_front());
    end
    if (ifb.mix_valid) begin
      vcnt_b++;
      if (exp_b.size() == 0) chk("mix_b_unexpected", 1, 0);
      else chk("mix_b", ifb.mix_out, exp_b.pop_front());
    end
  end

  // One frame; optional second tick (with optional err_clr) tick2 cycles later.
  task automatic frame(input int ea, input int eb, input int tick2, input bit clr2, output int lat);
    int t0;
    bit done;
    done = 0; lat = -1;
    exp_a.push_back(ea); exp_b.push_back(eb);
    @(posedge clk); #1; tick = 1'b1; t0 = cyc;
    @(posedge clk); #1; tick = 1'b0;
    if (tick2 > 0) begin
      repeat (tick2 - 1) @(posedge clk);
      #1; tick = 1'b1; clr = clr2;
      @(posedge clk); #1; tick = 1'b0; clr = 1'b0;
    end
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (ifa.mix_valid) begin done = 1; lat = cyc - t0; end
    end
    if (!done) chk("frame_done", 0, 1);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat, v0;
    samp = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
    dly = '{default: 0};
    mute = '{default: 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mix_out", ifa.mix_out, 0);
    chk("rst_mix_valid", ifa.mix_valid, 0);
    chk("rst_req", ifa.voice_req, 0);
    chk("rst_sel", ifa.voice_sel, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_errs", {ifa.overrun_err, ifa.timeout_err}, 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);

    samp = '{16'sd1000, 16'sd2000, -16'sd500, 16'sd300};
    frame(700, 2800, 0, 0, lat);
    chk("latency_all_en", lat, 9);

    samp = '{16'sd30000, 16'sd30000, 16'sd30000, 16'sd30000};
    frame(30000, 32767, 0, 0, lat);
    samp = '{-16'sd30000, -16'sd30000, -16'sd30000, -16'sd30000};
    frame(-30000, -32768, 0, 0, lat);

    en = 4'b1010; req_mask = 0;
    samp = '{16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000};
    frame(1500, 6000, 0, 0, lat);
    chk("req_sel_mask", req_mask, 4'b1010);

    en = 4'b0000; req_mask = 0;
    frame(0, 0, 0, 0, lat);
    chk("latency_all_off", lat, 5);
    chk("req_mask_off", req_mask, 0);

    en = 4'hF; mute[2] = 1;
    samp = '{16'sd1000, 16'sd2000, 16'sd9999, -16'sd200};
    chk("tmo_before", ifa.timeout_err, 0);
    frame(700, 2800, 0, 0, lat);
    chk("tmo_set_a", ifa.timeout_err, 1);
    chk("tmo_set_b", ifb.timeout_err, 1);
    mute[2] = 0;
    pulse_clr();
    chk("tmo_clr", ifa.timeout_err, 0);

    samp = '{16'sd1000, 16'sd2000, -16'sd500, 16'sd300};
    chk("ovr_before", ifa.overrun_err, 0);
    v0 = vcnt_a;
    frame(700, 2800, 1, 1, lat);
    chk("latency_overrun", lat, 9);
    chk("ovr_set_wins", ifa.overrun_err, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("ovr_one_valid", vcnt_a - v0, 1);
    pulse_clr();
    chk("ovr_clr", ifa.overrun_err, 0);

    v0 = vcnt_a;
    @(posedge clk); #1; stray_ack = 1'b1; sample_r = 16'sh1234;
    repeat (4) @(posedge clk);
    #1; stray_ack = 1'b0;
    @(negedge clk);
    chk("stray_busy", ifa.busy, 0);
    chk("stray_no_valid", vcnt_a - v0, 0);
    chk("stray_mix_hold", ifa.mix_out, 700);
    samp = '{16'sd100, 16'sd200, 16'sd300, 16'sd400};
    frame(250, 1000, 0, 0, lat);

    samp = '{16'sd1000, 16'sd2000, -16'sd500, 16'sd300};
    dly[1] = 10; v0 = vcnt_a;
    @(posedge clk); #1; tick = 1'b1;
    @(posedge clk); #1; tick = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_sel", ifa.voice_sel, 1);
    chk("pre_rst_busy", ifa.busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", ifa.busy, 0);
    chk("mid_rst_sel", ifa.voice_sel, 0);
    chk("mid_rst_mix", ifa.mix_out, 0);
    chk("mid_rst_valid", ifa.mix_valid, 0);
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; pend_sel = -1; dly[1] = 0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("rst_no_valid", vcnt_a - v0, 0);
    frame(700, 2800, 0, 0, lat);
    chk("latency_after_rst", lat, 9);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_a_drained", exp_a.size(), 0);
    chk("queue_b_drained", exp_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
